axi_ar_xbar_rr: RTL and testbench

Parametrised AXI read-address (AR) crossbar connecting NUM_M masters to NUM_S slaves. Each slave port has its own round-robin arbiter with grant lock and an optional one-entry register slice. The address decode is internal and parameter-driven. It replaces the fixed 2x5 AR router in the bus fabric. It widens ARID with the master index so the R-channel router can return data to the correct master.

---
 rtl/axi_ar_xbar_rr.sv | 169 ++++++++++++++++
 tb/tb_axi_ar_xbar_rr.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ar_xbar_rr.sv
// rtl/axi_ar_xbar_rr.sv - NUM_M x NUM_S AXI read-address crossbar with per-slave locked round-robin arbiters
// Optional per-slave one-entry register slice enabled by defining AXI_AR_REG_SLICE_EN.
module axi_ar_xbar_rr #(
  parameter int NUM_M = 2,
  parameter int NUM_S = 5,
  parameter int ID_W = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W = 4,
  parameter logic [NUM_S*ADDR_W-1:0] SLV_BASE = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000,
                                                 32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_S*ADDR_W-1:0] SLV_MASK = {NUM_S{32'hFFFF_0000}},
  parameter int DEFAULT_S = 0,
  localparam int MI_W = (NUM_M > 1) ? $clog2(NUM_M) : 1,
  localparam int SID_W = ID_W + MI_W
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [NUM_M*ID_W-1:0]   ARID_M,
  input  logic [NUM_M*ADDR_W-1:0] ARADDR_M,
  input  logic [NUM_M*LEN_W-1:0]  ARLEN_M,
  input  logic [NUM_M*3-1:0]      ARSIZE_M,
  input  logic [NUM_M*2-1:0]      ARBURST_M,
  input  logic [NUM_M-1:0]        ARVALID_M,
  output logic [NUM_M-1:0]        ARREADY_M,
  output logic [NUM_S*SID_W-1:0]  ARID_S,
  output logic [NUM_S*ADDR_W-1:0] ARADDR_S,
  output logic [NUM_S*LEN_W-1:0]  ARLEN_S,
  output logic [NUM_S*3-1:0]      ARSIZE_S,
  output logic [NUM_S*2-1:0]      ARBURST_S,
  output logic [NUM_S-1:0]        ARVALID_S,
  input  logic [NUM_S-1:0]        ARREADY_S
);

  localparam int TI_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;

  logic [TI_W-1:0]  tgt [NUM_M];
  logic [NUM_M-1:0] rdy_sm [NUM_S];

  // Descending scan so the lowest matching slave index is the one left standing.
  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      tgt[m] = TI_W'(DEFAULT_S);
      for (int s = NUM_S - 1; s >= 0; s--) begin
        if ((ARADDR_M[m*ADDR_W +: ADDR_W] & SLV_MASK[s*ADDR_W +: ADDR_W]) == SLV_BASE[s*ADDR_W +: ADDR_W])
          tgt[m] = TI_W'(s);
      end
    end
  end

  always_comb begin
    ARREADY_M = '0;
    for (int s = 0; s < NUM_S; s++)
      ARREADY_M = ARREADY_M | rdy_sm[s];
  end

  for (genvar s = 0; s < NUM_S; s++) begin : g_slv
    logic [NUM_M-1:0]  req;
    logic              pick_vld;
    logic [MI_W-1:0]   pick_idx;
    logic [MI_W-1:0]   cand;
    logic              locked;
    logic [MI_W-1:0]   lock_idx;
    logic [MI_W-1:0]   rr_ptr;
    logic              gnt_vld;
    logic [MI_W-1:0]   gnt_idx;
    logic              accept;
    logic              hs;
    logic [SID_W-1:0]  in_id;
    logic [ADDR_W-1:0] in_addr;
    logic [LEN_W-1:0]  in_len;
    logic [2:0]        in_size;
    logic [1:0]        in_burst;

    always_comb begin
      for (int m = 0; m < NUM_M; m++)
        req[m] = ARVALID_M[m] && (tgt[m] == TI_W'(s));
    end

    always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int k = 1; k <= NUM_M; k++) begin
        cand = MI_W'((int'(rr_ptr) + k) % NUM_M);
        if (!pick_vld && req[cand]) begin
          pick_vld = 1'b1;
          pick_idx = cand;
        end
      end
    end

    assign gnt_vld = locked || pick_vld;
    assign gnt_idx = locked ? lock_idx : pick_idx;
    assign hs      = gnt_vld && ARVALID_M[gnt_idx] && accept;
    assign rdy_sm[s] = (ARESETn && gnt_vld && accept) ? (NUM_M'(1) << gnt_idx) : '0;

    assign in_id    = {gnt_idx, ARID_M[int'(gnt_idx)*ID_W +: ID_W]};
    assign in_addr  = ARADDR_M[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign in_len   = ARLEN_M[int'(gnt_idx)*LEN_W +: LEN_W];
    assign in_size  = ARSIZE_M[int'(gnt_idx)*3 +: 3];
    assign in_burst = ARBURST_M[int'(gnt_idx)*2 +: 2];

    // Grant is frozen from the first un-handshaken cycle until the master completes.
    always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
        locked   <= 1'b0;
        lock_idx <= '0;
        rr_ptr   <= MI_W'(NUM_M - 1);
      end else if (hs) begin
        locked <= 1'b0;
        rr_ptr <= gnt_idx;
      end else if (gnt_vld && !locked) begin
        locked   <= 1'b1;
        lock_idx <= gnt_idx;
      end
    end

`ifdef AXI_AR_REG_SLICE_EN
    logic              full;
    logic [SID_W-1:0]  sl_id;
    logic [ADDR_W-1:0] sl_addr;
    logic [LEN_W-1:0]  sl_len;
    logic [2:0]        sl_size;
    logic [1:0]        sl_burst;

    assign accept = !full || ARREADY_S[s];

    always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
        full     <= 1'b0;
        sl_id    <= '0;
        sl_addr  <= '0;
        sl_len   <= '0;
        sl_size  <= '0;
        sl_burst <= '0;
      end else if (hs) begin
        full     <= 1'b1;
        sl_id    <= in_id;
        sl_addr  <= in_addr;
        sl_len   <= in_len;
        sl_size  <= in_size;
        sl_burst <= in_burst;
      end else if (ARREADY_S[s]) begin
        full <= 1'b0;
      end
    end

    assign ARVALID_S[s]                 = full;
    assign ARID_S[s*SID_W +: SID_W]     = sl_id;
    assign ARADDR_S[s*ADDR_W +: ADDR_W] = sl_addr;
    assign ARLEN_S[s*LEN_W +: LEN_W]    = sl_len;
    assign ARSIZE_S[s*3 +: 3]           = sl_size;
    assign ARBURST_S[s*2 +: 2]          = sl_burst;
`else
    logic pass;

    assign accept = ARREADY_S[s];
    assign pass   = ARESETn && gnt_vld;

    assign ARVALID_S[s]                 = pass && ARVALID_M[gnt_idx];
    assign ARID_S[s*SID_W +: SID_W]     = pass ? in_id : '0;
    assign ARADDR_S[s*ADDR_W +: ADDR_W] = pass ? in_addr : '0;
    assign ARLEN_S[s*LEN_W +: LEN_W]    = pass ? in_len : '0;
    assign ARSIZE_S[s*3 +: 3]           = pass ? in_size : '0;
    assign ARBURST_S[s*2 +: 2]          = pass ? in_burst : '0;
`endif
  end

endmodule

// File: tb/tb_axi_ar_xbar_rr.sv
// tb/tb_axi_ar_xbar_rr.sv - scoreboard bench for axi_ar_xbar_rr (default 2x5 map, 64 KiB windows)
module tb_axi_ar_xbar_rr;
  localparam int NM = 2;
  localparam int NS = 5;
  localparam int SW = 5;
`ifdef AXI_AR_REG_SLICE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic [NM*4-1:0]  arid_m;
  logic [NM*32-1:0] araddr_m;
  logic [NM*4-1:0]  arlen_m;
  logic [NM*3-1:0]  arsize_m;
  logic [NM*2-1:0]  arburst_m;
  logic [NM-1:0]    arvalid_m;
  logic [NM-1:0]    arready_m;
  logic [NS*SW-1:0] arid_s;
  logic [NS*32-1:0] araddr_s;
  logic [NS*4-1:0]  arlen_s;
  logic [NS*3-1:0]  arsize_s;
  logic [NS*2-1:0]  arburst_s;
  logic [NS-1:0]    arvalid_s;
  logic [NS-1:0]    arready_s;

  axi_ar_xbar_rr dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M(arid_m), .ARADDR_M(araddr_m), .ARLEN_M(arlen_m), .ARSIZE_M(arsize_m),
    .ARBURST_M(arburst_m), .ARVALID_M(arvalid_m), .ARREADY_M(arready_m),
    .ARID_S(arid_s), .ARADDR_S(araddr_s), .ARLEN_S(arlen_s), .ARSIZE_S(arsize_s),
    .ARBURST_S(arburst_s), .ARVALID_S(arvalid_s), .ARREADY_S(arready_s)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [SW-1:0] id;
    logic [31:0]   addr;
    logic [3:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } ar_t;

  ar_t q [NS][$];
  ar_t act_v, exp_v;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int m_hs [NM];
  int s_hs [NS];

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ar(input int s, input int m, input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    q[s].push_back({1'(m), id, addr, len, size, burst});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  // Drives one AR on master m and holds it until the master-side handshake.
  task automatic issue(input int m, input logic [3:0] id, input logic [31:0] addr,
                       input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n;
    arid_m[m*4 +: 4]     = id;
    araddr_m[m*32 +: 32] = addr;
    arlen_m[m*4 +: 4]    = len;
    arsize_m[m*3 +: 3]   = size;
    arburst_m[m*2 +: 2]  = burst;
    arvalid_m[m]         = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!arready_m[m] && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL issue_timeout m%0d: got no ARREADY_M expected handshake within 200 cycles", m);
    end
    m_hs[m] = cyc;
    @(posedge ACLK);
    #1;
    arvalid_m[m] = 1'b0;
  endtask

  always @(negedge ACLK) begin
    if (ARESETn) begin
      for (int s = 0; s < NS; s++) begin
        if (arvalid_s[s] && arready_s[s]) begin
          act_v = {arid_s[s*SW +: SW], araddr_s[s*32 +: 32], arlen_s[s*4 +: 4],
                   arsize_s[s*3 +: 3], arburst_s[s*2 +: 2]};
          s_hs[s] = cyc;
          checks++;
          if (q[s].size() == 0) begin
            errors++;
            $display("FAIL sb_s%0d: got AR %0h expected no transfer", s, act_v);
          end else begin
            exp_v = q[s].pop_front();
            if (act_v !== exp_v) begin
              errors++;
              $display("FAIL sb_s%0d: got AR %0h expected %0h", s, act_v, exp_v);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200us");
    $fatal(1);
  end

  initial begin
    arid_m = '0; araddr_m = '0; arlen_m = '0; arsize_m = '0; arburst_m = '0;
    arvalid_m = '0;
    arready_s = '1;
    for (int i = 0; i < NM; i++) m_hs[i] = 0;
    for (int i = 0; i < NS; i++) s_hs[i] = 0;

    // Both masters valid to slave 0 through reset; M0 must win first.
    expect_ar(0, 0, 4'h1, 32'h0000_0100, 4'h0, 3'h2, 2'b01);
    expect_ar(0, 1, 4'h2, 32'h0000_0200, 4'h1, 3'h2, 2'b01);
    fork
      issue(0, 4'h1, 32'h0000_0100, 4'h0, 3'h2, 2'b01);
      issue(1, 4'h2, 32'h0000_0200, 4'h1, 3'h2, 2'b01);
      begin
        repeat (3) @(negedge ACLK);
        chk("rst_arvalid_s", 64'(arvalid_s), 64'h0);
        chk("rst_arready_m", 64'(arready_m), 64'h0);
        chk("rst_payload", 64'(|{arid_s, araddr_s, arlen_s, arsize_s, arburst_s}), 64'h0);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("first_grant", 64'(arready_m), 64'h1);
      end
    join
    idle(3);

    // Single read through slave 1, ID widened to {1, 3}.
    expect_ar(1, 1, 4'h3, 32'h0001_0000, 4'h7, 3'h2, 2'b01);
    issue(1, 4'h3, 32'h0001_0000, 4'h7, 3'h2, 2'b01);
    idle(3);
    chk("single_latency", 64'(s_hs[1] - m_hs[1]), 64'(LAT));

    // Independent slaves granted in the same cycle.
    expect_ar(0, 0, 4'h4, 32'h0000_0040, 4'h1, 3'h1, 2'b00);
    expect_ar(4, 1, 4'h5, 32'h0004_0080, 4'h3, 3'h3, 2'b10);
    fork
      issue(0, 4'h4, 32'h0000_0040, 4'h1, 3'h1, 2'b00);
      issue(1, 4'h5, 32'h0004_0080, 4'h3, 3'h3, 2'b10);
    join
    idle(3);
    chk("parallel_same_cycle", 64'(m_hs[0] - m_hs[1]), 64'h0);
    chk("parallel_lat_s0", 64'(s_hs[0] - m_hs[0]), 64'(LAT));
    chk("parallel_lat_s4", 64'(s_hs[4] - m_hs[1]), 64'(LAT));

    // Contention on slave 2: grants must alternate M0, M1, M0, M1, ...
    for (int i = 0; i < 4; i++) begin
      expect_ar(2, 0, 4'(i), 32'h0002_0000 + 32'(i*16), 4'h0, 3'h2, 2'b01);
      expect_ar(2, 1, 4'(8+i), 32'h0002_1000 + 32'(i*16), 4'h1, 3'h2, 2'b01);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) issue(0, 4'(i), 32'h0002_0000 + 32'(i*16), 4'h0, 3'h2, 2'b01);
      end
      begin
        for (int j = 0; j < 4; j++) issue(1, 4'(8+j), 32'h0002_1000 + 32'(j*16), 4'h1, 3'h2, 2'b01);
      end
    join
    idle(3);

    // Lock under backpressure on slave 3: M1 holds the slave, M0 waits.
    arready_s[3] = 1'b0;
    expect_ar(3, 1, 4'h6, 32'h0003_0010, 4'hF, 3'h2, 2'b01);
    expect_ar(3, 0, 4'h7, 32'h0003_0020, 4'h0, 3'h3, 2'b01);
    fork
      issue(1, 4'h6, 32'h0003_0010, 4'hF, 3'h2, 2'b01);
      begin
        idle(2);
        issue(0, 4'h7, 32'h0003_0020, 4'h0, 3'h3, 2'b01);
      end
      begin
        idle(2);
        repeat (5) begin
          @(negedge ACLK);
          chk("lock_arvalid_s3", 64'(arvalid_s[3]), 64'h1);
          chk("lock_arid_s3", 64'(arid_s[3*SW +: SW]), 64'h16);
          chk("lock_araddr_s3", 64'(araddr_s[3*32 +: 32]), 64'h0003_0010);
          chk("lock_m0_blocked", 64'(arready_m[0]), 64'h0);
        end
        @(posedge ACLK);
        #1;
        arready_s[3] = 1'b1;
      end
    join
    idle(3);

    // Unmapped address falls to the default slave 0.
    expect_ar(0, 0, 4'hA, 32'hFFFF_0000, 4'h2, 3'h0, 2'b01);
    issue(0, 4'hA, 32'hFFFF_0000, 4'h2, 3'h0, 2'b01);
    idle(4);

    for (int s = 0; s < NS; s++) chk($sformatf("sb_drained_s%0d", s), 64'(q[s].size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
